// File: rtl/delay_line_ctrl_if.sv
// Valid/ready handshake bundle around the controlled delay chain: intake at d, delivery at q.
// The controller takes the slave modport; the upstream/downstream side takes master.
interface delay_line_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport slave (
    input  in_valid,
    output in_ready,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_valid,
    input  in_ready,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Valid-shadow controller for a DEPTH-stage shift chain; a bit accepted in cycle t is presented in cycle t+DEPTH.
// A valid q stalled by out_ready=0 freezes the whole chain and intake; drain stops intake and empties the chain.
module delay_line_ctrl #(
  parameter  int DEPTH = 4,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  delay_line_ctrl_if.slave      bus,
  input  logic                  drain,
  output logic                  en,
  output logic [OW-1:0]         occupancy,
  output logic                  busy,
  output logic                  drain_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             drain_arm_q, drain_arm_d;
  logic             drain_done_q, drain_done_d;
  logic             accept, deliver, drain_trig;

  // vld_q[DEPTH-1] shadows the q stage; a stalled valid q is the only thing that stops the chain.
  assign en            = bus.out_ready | ~vld_q[DEPTH-1];
  assign drain_trig    = drain & drain_arm_q & (state_q != DRAIN);
  assign bus.in_ready  = en & (state_q != DRAIN) & ~drain_trig;
  assign bus.out_valid = vld_q[DEPTH-1];
  assign accept        = bus.in_valid & bus.in_ready;
  assign deliver       = bus.out_valid & bus.out_ready;

  assign occupancy  = occ_q;
  assign busy       = (state_q != IDLE);
  assign drain_done = drain_done_q;

  always_comb begin
    vld_d = vld_q;
    if (en) begin
      vld_d[0] = accept;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  assign occ_d = occ_q + OW'(accept) - OW'(deliver);

  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    drain_arm_d  = drain_arm_q;
    if (drain_trig) begin
      drain_arm_d = 1'b0;
    end else if (!drain && state_q != DRAIN) begin
      drain_arm_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (drain_trig) begin
          state_d = DRAIN;
        end else if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (drain_trig) begin
          state_d = DRAIN;
        end else if (occ_d == '0) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (occ_d == '0) begin
          state_d      = IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drain re-arms only after drain is seen low outside DRAIN, so a held request fires once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      vld_q        <= '0;
      occ_q        <= '0;
      drain_arm_q  <= 1'b1;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      occ_q        <= occ_d;
      drain_arm_q  <= drain_arm_d;
      drain_done_q <= drain_done_d;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed and random checks of delay_line_ctrl at DEPTH=4 with a bench-side data chain and queue scoreboard.
module tb_delay_line_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       drain;
  logic       en;
  logic [2:0] occupancy;
  logic       busy;
  logic       drain_done;
  int         n_cmp = 0;
  int         n_err = 0;

  delay_line_ctrl_if bus();

  delay_line_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .drain      (drain),
    .en         (en),
    .occupancy  (occupancy),
    .busy       (busy),
    .drain_done (drain_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; drain = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #3;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (drain_done !== 1'b0) begin n_err++; $display("FAIL rst_drain_done got %b want 0", drain_done); end
    n_cmp++; if (en !== 1'b1) begin n_err++; $display("FAIL rst_en got %b want 1", en); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    step();
    rst = 1'b1;
  endtask

  task automatic test_stream();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++; if (occupancy !== 3'(k)) begin n_err++; $display("FAIL stream_occ cycle %0d got %0d want %0d", k, occupancy, k); end
      n_cmp++; if (bus.out_valid !== (k == 4)) begin n_err++; $display("FAIL stream_out_valid cycle %0d got %b want %b", k, bus.out_valid, (k == 4)); end
    end
    step();
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL stream_settle got %0d want 4", occupancy); end
    n_cmp++; if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL stream_steady got ov=%b busy=%b want 1/1", bus.out_valid, busy); end
    bus.in_valid = 1'b0;
    repeat (4) step();
    n_cmp++; if (occupancy !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL stream_flush got occ=%0d busy=%b want 0/0", occupancy, busy); end
  endtask

  task automatic load_1011();
    logic [3:0] pat;
    pat = 4'b1101;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = pat[i];
      step();
    end
  endtask

  task automatic test_stall();
    load_1011();
    n_cmp++; if (bus.out_valid !== 1'b1 || occupancy !== 3'd3) begin n_err++; $display("FAIL stall_load got ov=%b occ=%0d want 1/3", bus.out_valid, occupancy); end
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    #1;
    n_cmp++; if (en !== 1'b0 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_en got en=%b in_ready=%b want 0/0", en, bus.in_ready); end
    repeat (3) step();
    n_cmp++; if (occupancy !== 3'd3 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold got occ=%0d ov=%b want 3/1", occupancy, bus.out_valid); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    n_cmp++; if (occupancy !== 3'd2 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got occ=%0d ov=%b want 2/0", occupancy, bus.out_valid); end
    step();
    n_cmp++; if (occupancy !== 3'd2 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_gap got occ=%0d ov=%b want 2/1", occupancy, bus.out_valid); end
    repeat (2) step();
    n_cmp++; if (occupancy !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL stall_empty got occ=%0d busy=%b want 0/0", occupancy, busy); end
  endtask

  task automatic test_drain();
    int deliv, pulses;
    deliv = 0; pulses = 0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (3) step();
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL drain_load got %0d want 3", occupancy); end
    drain = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL drain_priority got in_ready=%b want 0", bus.in_ready); end
    step();
    drain = 1'b0;
    n_cmp++; if (busy !== 1'b1 || occupancy !== 3'd3 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL drain_enter got busy=%b occ=%0d in_ready=%b want 1/3/0", busy, occupancy, bus.in_ready); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) deliv++;
      step();
      if (drain_done) pulses++;
      if (!busy) break;
    end
    bus.in_valid = 1'b0;
    step();
    if (drain_done) pulses++;
    n_cmp++; if (deliv !== 3) begin n_err++; $display("FAIL drain_deliveries got %0d want 3", deliv); end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL drain_done_pulses got %0d want 1", pulses); end
    n_cmp++; if (occupancy !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL drain_final got occ=%0d busy=%b want 0/0", occupancy, busy); end
  endtask

  task automatic test_drain_empty();
    drain = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b1 || drain_done !== 1'b0) begin n_err++; $display("FAIL empty_drain_enter got busy=%b dd=%b want 1/0", busy, drain_done); end
    step();
    n_cmp++; if (busy !== 1'b0 || drain_done !== 1'b1) begin n_err++; $display("FAIL empty_drain_exit got busy=%b dd=%b want 0/1", busy, drain_done); end
    step();
    n_cmp++; if (busy !== 1'b0 || drain_done !== 1'b0) begin n_err++; $display("FAIL drain_held_no_retrigger got busy=%b dd=%b want 0/0", busy, drain_done); end
    drain = 1'b0;
    step();
    drain = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drain_rearm got busy=%b want 1", busy); end
    drain = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || drain_done !== 1'b1) begin n_err++; $display("FAIL drain_rearm_done got busy=%b dd=%b want 0/1", busy, drain_done); end
    step();
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    load_1011();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    step();
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL rmid_load got %0d want 3", occupancy); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || occupancy !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_async got ov=%b occ=%0d busy=%b want 0/0/0", bus.out_valid, occupancy, busy); end
    repeat (2) begin step(); if (drain_done) pulses++; end
    rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    if (drain_done) pulses++;
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL rmid_first_accept got %0d want 1", occupancy); end
    bus.in_valid = 1'b0;
    repeat (4) begin step(); if (drain_done) pulses++; end
    n_cmp++; if (pulses !== 0 || busy !== 1'b0 || occupancy !== 3'd0) begin n_err++; $display("FAIL rmid_after got dd_pulses=%0d busy=%b occ=%0d want 0/0/0", pulses, busy, occupancy); end
  endtask

  task automatic test_random();
    logic       in_bit, acc, del, en_s, exp_bit;
    logic [3:0] dchain;
    logic       sb_q[$];
    int         sb_occ;
    int         errs_before;
    dchain = '0; sb_occ = 0; in_bit = 1'b0;
    errs_before = n_err;
    for (int n = 0; n < 10000; n++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      in_bit        = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc  = bus.in_valid & bus.in_ready;
      del  = bus.out_valid & bus.out_ready;
      en_s = en;
      if (del) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++; $display("FAIL rand_spurious_out cycle %0d got out_valid=1 want 0", n);
        end else begin
          exp_bit = sb_q.pop_front();
          sb_occ--;
          if (dchain[3] !== exp_bit) begin n_err++; $display("FAIL rand_data cycle %0d got %b want %b", n, dchain[3], exp_bit); end
        end
      end
      if (acc) begin
        sb_q.push_back(in_bit);
        sb_occ++;
      end
      @(posedge clk);
      if (en_s) dchain = {dchain[2:0], in_bit};
      #1;
      n_cmp++;
      if (int'(occupancy) !== sb_occ || sb_occ > DEPTH) begin
        n_err++; $display("FAIL rand_occupancy cycle %0d got %0d want %0d", n, occupancy, sb_occ);
      end
      if (n_err - errs_before > 10) break;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_drain();
    test_drain_empty();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
